// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  // Counter width able to hold the value `width`.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned Latency      = DefaultWidth + 1;

endpackage

// File: rtl/multdiv_divider.sv
// Restoring unsigned divider: one quotient bit per step_i, operand magnitudes loaded on load_i.
module multdiv_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] diff_lo;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign fits      = (rem_shift >= {1'b0, dvs_q});
  assign diff_lo   = WIDTH'(rem_shift - {1'b0, dvs_q});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      // A remainder below the divisor never sets rem_shift[WIDTH], so the low bits suffice.
      rem_q <= fits ? diff_lo : rem_shift[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], fits};
    end
  end

  assign quotient_o = quo_q;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, WIDTH+1 cycle latency.
// The divider datapath is compiled in only when MULTDIV_DIV_EN is defined.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CntW = cnt_w(WIDTH);

  state_e state_q, state_d;

  logic               start_mul, start_div, start, last_step;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   op_a_q;
  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH:0]     booth_hi, booth_m, booth_sum;
  logic [2*WIDTH-1:0] product;
  logic               mul_ovf;
  logic [WIDTH-1:0]   div_result;
  logic               div_exc;

  assign start_mul = ctrl_MULT & ~ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign start     = start_mul | start_div;
  assign last_step = (cnt_q == CntW'(WIDTH));

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_mul) begin
      state_d = StMul;
    end else if (start_div) begin
      state_d = StDiv;
    end else begin
      unique case (state_q)
        StMul, StDiv: if (last_step) state_d = StDone;
        StDone:       state_d = StIdle;
        default:      state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q == StMul) || (state_q == StDiv);
    data_resultRDY = (state_q == StDone);
  end

  // Partial sum kept one bit wider so a most-negative multiplicand cannot wrap.
  assign booth_hi = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
  assign booth_m  = {op_a_q[WIDTH-1], op_a_q};

  always_comb begin
    booth_sum = booth_hi;
    case (acc_q[1:0])
      2'b01:   booth_sum = booth_hi + booth_m;
      2'b10:   booth_sum = booth_hi - booth_m;
      default: booth_sum = booth_hi;
    endcase
  end

  assign product = acc_q[2*WIDTH:1];
  assign mul_ovf = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q          <= '0;
      op_a_q         <= '0;
      acc_q          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      cnt_q          <= '0;
      op_a_q         <= data_operandA;
      acc_q          <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (busy) begin
      if (!last_step) begin
        cnt_q <= cnt_q + CntW'(1);
        if (state_q == StMul) acc_q <= {booth_sum, acc_q[WIDTH:1]};
      end else if (state_q == StMul) begin
        data_result    <= product[WIDTH-1:0];
        data_exception <= mul_ovf;
      end else begin
        data_result    <= div_result;
        data_exception <= div_exc;
      end
    end
  end

`ifdef MULTDIV_DIV_EN
  logic [WIDTH-1:0] a_mag, b_mag, quo_mag;
  logic             div_fault_q, quot_neg_q;

  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_fault_q <= 1'b0;
      quot_neg_q  <= 1'b0;
    end else if (start_div) begin
      div_fault_q <= (data_operandB == '0) ||
                     ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1));
      quot_neg_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
    end
  end

  multdiv_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (start_div),
    .step_i     ((state_q == StDiv) && !last_step && !start),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quotient_o (quo_mag)
  );

  always_comb begin
    div_exc    = div_fault_q;
    div_result = '0;
    if (!div_fault_q) div_result = quot_neg_q ? -quo_mag : quo_mag;
  end
`else
  assign div_result = '0;
  assign div_exc    = 1'b1;
`endif

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit at WIDTH=32; honours MULTDIV_DIV_EN if defined.
module tb_multdiv_unit;

`ifdef MULTDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  multdiv_unit #(
    .WIDTH (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Caller must be at a negedge. Issues one start pulse, scrambles the operands afterwards,
  // then waits (bounded) for RDY. lat is the edge count from the start edge to RDY (-1: none).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic mul,
                       input logic div, output int lat, output logic [31:0] res,
                       output logic exc, output logic busy_ok);
    int k;
    bit done;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = ~a;
    data_operandB = b + 32'd3;
    busy_ok = (busy === 1'b1) && (data_resultRDY === 1'b0);
    lat  = -1;
    res  = 'x;
    exc  = 1'bx;
    k    = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
      if (data_resultRDY === 1'b1) begin
        done = 1'b1;
        lat  = k;
        res  = data_result;
        exc  = data_exception;
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    total++; if (data_result !== 32'd0) begin bad++;
      $display("FAIL reset_result: got %h want 00000000", data_result); end
    total++; if (data_exception !== 1'b0) begin bad++;
      $display("FAIL reset_exc: got %b want 0", data_exception); end
    total++; if (data_resultRDY !== 1'b0) begin bad++;
      $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_mul();
    logic [31:0] a_tab [5] = '{32'd7, 32'h4000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] b_tab [5] = '{32'hFFFF_FFFA, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] r_tab [5] = '{32'hFFFF_FFD6, 32'h0, 32'd1, 32'h8000_0001, 32'h0};
    logic        e_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    logic [31:0] res;
    logic exc, bok;
    for (int i = 0; i < 5; i++) begin
      do_op(a_tab[i], b_tab[i], 1'b1, 1'b0, lat, res, exc, bok);
      total++; if (lat != 33) begin bad++;
        $display("FAIL mul%0d_latency: got %0d want 33", i, lat); end
      total++; if (res !== r_tab[i]) begin bad++;
        $display("FAIL mul%0d_result: got %h want %h", i, res, r_tab[i]); end
      total++; if (exc !== e_tab[i]) begin bad++;
        $display("FAIL mul%0d_exc: got %b want %b", i, exc, e_tab[i]); end
      total++; if (!bok) begin bad++;
        $display("FAIL mul%0d_busy: got busy window wrong want high from start to RDY", i); end
      @(negedge clock);
      total++; if (data_resultRDY !== 1'b0 || data_result !== r_tab[i]) begin bad++;
        $display("FAIL mul%0d_hold: got rdy=%b res=%h want rdy=0 res=%h", i, data_resultRDY,
                 data_result, r_tab[i]); end
    end
  endtask

  task automatic test_div();
    logic [31:0] a_tab [6] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9};
    logic [31:0] b_tab [6] = '{32'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd3};
    logic [31:0] r_tab [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'd0, 32'd0, 32'hC000_0000, 32'd3};
    logic        e_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    logic [31:0] res, exp_r;
    logic exc, bok, exp_e;
    for (int i = 0; i < 6; i++) begin
      exp_r = DivEn ? r_tab[i] : 32'd0;
      exp_e = DivEn ? e_tab[i] : 1'b1;
      do_op(a_tab[i], b_tab[i], 1'b0, 1'b1, lat, res, exc, bok);
      total++; if (lat != 33) begin bad++;
        $display("FAIL div%0d_latency: got %0d want 33", i, lat); end
      total++; if (res !== exp_r) begin bad++;
        $display("FAIL div%0d_result: got %h want %h", i, res, exp_r); end
      total++; if (exc !== exp_e) begin bad++;
        $display("FAIL div%0d_exc: got %b want %b", i, exc, exp_e); end
      total++; if (!bok) begin bad++;
        $display("FAIL div%0d_busy: got busy window wrong want high from start to RDY", i); end
      @(negedge clock);
    end
  endtask

  task automatic test_restart();
    int rdy_cnt, first_k;
    logic [31:0] res;
    data_operandA = 32'd3; data_operandB = 32'd3; ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    rdy_cnt = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_cnt++;
    end
    data_operandA = 32'd4; data_operandB = 32'd5; ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0; data_operandA = 32'd9; data_operandB = 32'd9;
    first_k = -1;
    res = 'x;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (first_k < 0) begin first_k = k; res = data_result; end
      end
    end
    total++; if (rdy_cnt != 1) begin bad++;
      $display("FAIL restart_rdy_count: got %0d want 1", rdy_cnt); end
    total++; if (first_k != 33) begin bad++;
      $display("FAIL restart_latency: got %0d want 33", first_k); end
    total++; if (res !== 32'd20) begin bad++;
      $display("FAIL restart_result: got %h want 00000014", res); end
  endtask

  task automatic test_both_high();
    int busy_cnt, rdy_cnt;
    data_operandA = 32'd2; data_operandB = 32'd2;
    ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    rdy_cnt  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (busy === 1'b1) busy_cnt++;
      if (data_resultRDY === 1'b1) rdy_cnt++;
    end
    total++; if (busy_cnt != 0) begin bad++;
      $display("FAIL both_busy: got %0d busy cycles want 0", busy_cnt); end
    total++; if (rdy_cnt != 0) begin bad++;
      $display("FAIL both_rdy: got %0d rdy pulses want 0", rdy_cnt); end
  endtask

  task automatic test_reset_mid();
    int rdy_cnt, busy_cnt;
    data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin bad++;
      $display("FAIL midreset_ctrl: got busy=%b rdy=%b want 0 0", busy, data_resultRDY); end
    total++; if (data_result !== 32'd0 || data_exception !== 1'b0) begin bad++;
      $display("FAIL midreset_data: got res=%h exc=%b want 0 0", data_result, data_exception); end
    rdy_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) rdy_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    total++; if (rdy_cnt != 0 || busy_cnt != 0) begin bad++;
      $display("FAIL midreset_quiet: got rdy=%0d busy=%0d want 0 0", rdy_cnt, busy_cnt); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    logic exc, bok;
    do_op(32'd6, 32'd7, 1'b1, 1'b0, lat, res, exc, bok);
    total++; if (lat != 33 || res !== 32'd42 || exc !== 1'b0) begin bad++;
      $display("FAIL b2b_first: got lat=%0d res=%h exc=%b want 33 0000002a 0", lat, res, exc);
    end
    // Still in the RDY cycle: launch the next op straight away.
    do_op(32'd2, 32'hFFFF_FFFD, 1'b1, 1'b0, lat, res, exc, bok);
    total++; if (lat != 33 || res !== 32'hFFFF_FFFA || exc !== 1'b0) begin bad++;
      $display("FAIL b2b_second: got lat=%0d res=%h exc=%b want 33 fffffffa 0", lat, res, exc);
    end
    total++; if (!bok) begin bad++;
      $display("FAIL b2b_busy: got busy window wrong want high from start to RDY"); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_restart();
    test_both_high();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
